// File: rtl/onoff_button_conditioner_if.sv
// Pushbutton conditioner interface.
// Carries the raw button input and the conditioned outputs of
// onoff_button_conditioner.
//   button      : raw pushbutton, asynchronous, 1 = pressed
//   OnOff       : registered on/off level to the toggle stage
//   pressed     : debounced button level
//   press_pulse : one-cycle pulse per accepted press
//   long_pulse  : one-cycle pulse on long-press force-off (0 when the feature is disabled)
// Modports: master drives the button and observes the outputs; slave is the conditioner.
interface onoff_button_conditioner_if;
    logic button;
    logic OnOff;
    logic pressed;
    logic press_pulse;
    logic long_pulse;

    modport master (
        output button,
        input  OnOff,
        input  pressed,
        input  press_pulse,
        input  long_pulse
    );

    modport slave (
        input  button,
        output OnOff,
        output pressed,
        output press_pulse,
        output long_pulse
    );
endinterface

// File: rtl/onoff_button_conditioner.sv
// onoff_button_conditioner
// Turns a raw mechanical pushbutton into a clean on/off level. The module first
// synchronizes the raw input with two flops. A counter-qualified FSM then debounces
// it. OnOff flips once per accepted press. Releases never toggle OnOff.
//
// Optional feature: define ONOFF_LONGPRESS_EN to enable long-press force-off.
// With the feature enabled, holding the button for LONGPRESS_CYCLES cycles after
// acceptance clears OnOff and pulses long_pulse. This happens once per press.
// Without the macro, no hold counter is built and long_pulse is tied to 0.
//
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-low reset
//   btn   : onoff_button_conditioner_if.slave (button in; OnOff, pressed,
//           press_pulse, long_pulse out; all outputs registered)
module onoff_button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES  = 1_000_000,
    parameter int unsigned LONGPRESS_CYCLES = 150_000_000
) (
    input  logic                        clock,
    input  logic                        reset,
    onoff_button_conditioner_if.slave   btn
);

    localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    // The sample that leaves IDLE/PRESSED counts as the first stable sample,
    // so the wait state accepts on its (DEBOUNCE_CYCLES-1)-th stable sample.
    localparam int unsigned CNT_LAST = DEBOUNCE_CYCLES - 2;
    localparam int unsigned HOLD_W   = 32;

    // Parameter sanity checks at elaboration time
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (LONGPRESS_CYCLES < 1) begin : g_bad_longpress
        $error("LONGPRESS_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [1:0]         sync_q;
    logic               btn_s;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               cnt_last;
    logic               press_done;
    logic               release_done;
    logic               onoff_q;
    logic               onoff_d;
    logic               pressed_q;
    logic               pressed_d;
    logic               press_pulse_q;
    logic               press_pulse_d;

    // Two-flop synchronizer; only btn_s feeds the logic
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn.button};
        end
    end

    assign btn_s    = sync_q[1];
    assign cnt_last = (cnt_q == CNT_W'(CNT_LAST));

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and accept events
    always_comb begin
        state_d      = state_q;
        press_done   = 1'b0;
        release_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_s) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (cnt_last) begin
                    state_d    = PRESSED;
                    press_done = 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_s) state_d = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = PRESSED;
                end else if (cnt_last) begin
                    state_d      = IDLE;
                    release_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ONOFF_LONGPRESS_EN
    logic [HOLD_W-1:0]  hold_q;
    logic [HOLD_W-1:0]  hold_d;
    logic               long_fire;
    logic               long_pulse_q;

    // Fires on the LONGPRESS_CYCLES-th PRESSED cycle. The counter then saturates,
    // so the force-off fires at most once per press. Acceptance happens in PRESS_WAIT,
    // so acceptance always occurs before the long press.
    assign long_fire = (state_q == PRESSED) &&
                       (hold_q == HOLD_W'(LONGPRESS_CYCLES - 1));

    // Hold counter: counts in PRESSED, keeps its value across RELEASE_WAIT bounces,
    // and clears only when a release is accepted.
    always_comb begin
        hold_d = hold_q;
        if (release_done) begin
            hold_d = '0;
        end else if ((state_q == PRESSED) && (hold_q < HOLD_W'(LONGPRESS_CYCLES))) begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_q       <= '0;
            long_pulse_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            long_pulse_q <= long_fire;
        end
    end

    assign btn.long_pulse = long_pulse_q;
`else
    assign btn.long_pulse = 1'b0;
`endif

    // Output and counter next values
    always_comb begin
        cnt_d         = '0;
        pressed_d     = pressed_q;
        press_pulse_d = press_done;
        onoff_d       = onoff_q;

        // Count consecutive stable samples in the wait states; saturate rather than wrap
        if (((state_q == PRESS_WAIT) && btn_s && !cnt_last) ||
            ((state_q == RELEASE_WAIT) && !btn_s && !cnt_last)) begin
            cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        end

        if (press_done) begin
            pressed_d = 1'b1;
            onoff_d   = ~onoff_q;
        end
        if (release_done) begin
            pressed_d = 1'b0;
        end
`ifdef ONOFF_LONGPRESS_EN
        if (long_fire) begin
            onoff_d = 1'b0;
        end
`endif
    end

    // Output and counter registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q         <= '0;
            onoff_q       <= 1'b0;
            pressed_q     <= 1'b0;
            press_pulse_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            onoff_q       <= onoff_d;
            pressed_q     <= pressed_d;
            press_pulse_q <= press_pulse_d;
        end
    end

    assign btn.OnOff       = onoff_q;
    assign btn.pressed     = pressed_q;
    assign btn.press_pulse = press_pulse_q;

endmodule

// File: tb/tb_onoff_button_conditioner.sv
// Self-checking bench for onoff_button_conditioner (DEBOUNCE_CYCLES=4, LONGPRESS_CYCLES=20).
// A behavioural model in this file predicts the outputs each cycle:
//   - a 2-deep delay line stands in for the synchronizer;
//   - a sliding window of the last DEBOUNCE_CYCLES samples decides level changes;
//   - a hold count tracks pressed cycles for the optional long-press force-off.
// Directed scenarios pin key cycles with literal values, then randomized hold
// segments and reset pulses exercise the model comparison.
module tb_onoff_button_conditioner;

    localparam int unsigned DB = 4;
    localparam int unsigned LP = 20;
`ifdef ONOFF_LONGPRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    onoff_button_conditioner_if bif ();

    onoff_button_conditioner #(
        .DEBOUNCE_CYCLES  (DB),
        .LONGPRESS_CYCLES (LP)
    ) dut (
        .clock (clock),
        .reset (reset),
        .btn   (bif)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;
    int n_longs  = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_onoff, m_pressed, m_pulse, m_long, prev_s;
    int m_hold;
    bit raw_q[$];
    bit win[$];

    task automatic model_reset();
        m_onoff = 0; m_pressed = 0; m_pulse = 0; m_long = 0; prev_s = 0;
        m_hold = 0;
        raw_q = {1'b0, 1'b0};
        win.delete();
    endtask

    task automatic model_step(input bit b);
        bit s;
        bit all_diff;
        bit dropped;
        s = raw_q.pop_front();
        raw_q.push_back(b);
        m_pulse = 0;
        m_long  = 0;
        // While stably pressed (pressed and last sample high), count toward the long press
        if (LONG_EN && m_pressed && prev_s && (m_hold < int'(LP))) begin
            m_hold++;
            if (m_hold == int'(LP)) begin
                m_long  = 1;
                m_onoff = 0;
            end
        end
        win.push_back(s);
        if (win.size() > DB) dropped = win.pop_front();
        all_diff = (win.size() == DB);
        foreach (win[i]) if (win[i] == m_pressed) all_diff = 0;
        if (all_diff) begin
            m_pressed = !m_pressed;
            if (m_pressed) begin
                m_pulse = 1;
                m_onoff = !m_onoff;
            end else begin
                m_hold = 0;
            end
        end
        prev_s = s;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) model_reset();
            else        model_step(bif.button);
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clock);
            check("onoff_vs_model",   bif.OnOff,       m_onoff);
            check("pressed_vs_model", bif.pressed,     m_pressed);
            check("pulse_vs_model",   bif.press_pulse, m_pulse);
            check("long_vs_model",    bif.long_pulse,  m_long);
            if (bif.press_pulse === 1'b1) n_pulses++;
            if (bif.long_pulse === 1'b1)  n_longs++;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at posedge+2; returns at posedge+2 after n edges
    task automatic hold(input bit v, input int n);
        bif.button = v;
        repeat (n) @(posedge clock);
        #2;
    endtask

    // Advance n edges and stop 1 time unit after the last one
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        bit v;
        int n;
        bif.button = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        check("reset_onoff", bif.OnOff, 1'b0);
        check("reset_pressed", bif.pressed, 1'b0);
        reset = 1'b1;
        hold(0, 20);
        check("idle_onoff", bif.OnOff, 1'b0);
        check("idle_pressed", bif.pressed, 1'b0);

        // Clean press: outputs change exactly 6 edges after the raw rise
        bif.button = 1'b1;
        step(5);
        check("press_edge5_onoff", bif.OnOff, 1'b0);
        check("press_edge5_pulse", bif.press_pulse, 1'b0);
        step(1);
        check("press_edge6_onoff", bif.OnOff, 1'b1);
        check("press_edge6_pressed", bif.pressed, 1'b1);
        check("press_edge6_pulse", bif.press_pulse, 1'b1);
        step(1);
        check("press_edge7_pulse", bif.press_pulse, 1'b0);
        #1;
        hold(1, 4);
        // Release: pressed falls after 6 edges, OnOff holds
        bif.button = 1'b0;
        step(5);
        check("release_edge5_pressed", bif.pressed, 1'b1);
        step(1);
        check("release_edge6_pressed", bif.pressed, 1'b0);
        check("release_onoff", bif.OnOff, 1'b1);
        #1;
        hold(0, 4);
        // Second press toggles back to 0
        bif.button = 1'b1;
        step(6);
        check("second_press_onoff", bif.OnOff, 1'b0);
        #1;
        hold(1, 4);
        hold(0, 10);

        // Reset while held: accept, reset, re-accept after release of reset
        bif.button = 1'b1;
        step(6);
        check("held_press_onoff", bif.OnOff, 1'b1);
        #1;
        hold(1, 3);
        reset = 1'b0;
        #1;
        check("reset_async_onoff", bif.OnOff, 1'b0);
        check("reset_async_pressed", bif.pressed, 1'b0);
        #1;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        step(5);
        check("reheld_edge5_onoff", bif.OnOff, 1'b0);
        step(1);
        check("reheld_edge6_onoff", bif.OnOff, 1'b1);
        #1;
        hold(1, 3);
        hold(0, 10);

        // Bounce shorter than the debounce window: no pulse, no toggle
        n_pulses = 0;
        hold(1, 2); hold(0, 2); hold(1, 2); hold(0, 2); hold(0, 10);
        check("bounce_onoff", bif.OnOff, 1'b1);
        check("bounce_pressed", bif.pressed, 1'b0);
        check("bounce_no_pulse", (n_pulses == 0), 1'b1);

        // 3-cycle glitch during a held press: exactly one pulse
        n_pulses = 0;
        hold(1, 10); hold(0, 3); hold(1, 10);
        check("glitch_single_pulse", (n_pulses == 1), 1'b1);
        check("glitch_pressed", bif.pressed, 1'b1);
        check("glitch_onoff", bif.OnOff, 1'b0);
        hold(0, 10);

        // Long press: hold 30 cycles after acceptance
        n_longs = 0;
        bif.button = 1'b1;
        step(6);
        check("long_accept_onoff", bif.OnOff, 1'b1);
        step(19);
        check("long_edge19_pulse", bif.long_pulse, 1'b0);
        check("long_edge19_onoff", bif.OnOff, 1'b1);
        step(1);
        check("long_edge20_pulse", bif.long_pulse, LONG_EN);
        check("long_edge20_onoff", bif.OnOff, !LONG_EN);
        step(1);
        check("long_edge21_pulse", bif.long_pulse, 1'b0);
        #1;
        hold(1, 9);
        check("long_pulse_count", (n_longs == (LONG_EN ? 1 : 0)), 1'b1);
        hold(0, 10);
        check("long_after_release_onoff", bif.OnOff, !LONG_EN);

        // Randomized hold segments with occasional reset pulses
        repeat (150) begin
            v = 1'($urandom_range(0, 1));
            n = ($urandom % 8 == 0) ? int'($urandom_range(20, 32)) : int'($urandom_range(1, 7));
            if ($urandom % 40 == 0) begin
                reset = 1'b0;
                hold(v, 2);
                reset = 1'b1;
            end
            hold(v, n);
        end
        hold(0, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
